radix2_butterfly: RTL and testbench
===================================

RADIX2_BUTTERFLY -- requirements
Module: radix2_butterfly

Interface
REQ-001 bit_width, 29, signed width of each real and imaginary input component.
REQ-002 N, 16, samples per frame; power of two, at least 4.
REQ-003 SIZE, 4, log2(N); width of the output sample counter.
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 en_radix  input  1  input-sample valid; one sample per asserted cycle.
REQ-007 Re_i, Im_i  input  bit_width each  signed sample.
REQ-008 cos_data, sin_data  input  14 each  signed twiddle, Q2.12 (4096 = +1.0); W = cos_data + j*sin_data.
REQ-009 Re_o, Im_o  output  bit_width+1 each  signed butterfly result.
REQ-010 valid_o  output  1  Re_o/Im_o valid this cycle.
REQ-011 frame_done  output  1  single-cycle pulse coincident with the N-th valid output of a frame.

Function
REQ-012 Accepted samples pair in order: even-indexed = A, odd-indexed = B; a phase bit toggles on each accepted sample.
REQ-013 Twiddle is captured only with the B sample; the value present with A is ignored.
REQ-014 Product P = B*W: P_re = Br*c - Bi*s, P_im = Br*s + Bi*c; full-precision sums, then arithmetic shift right by 12 (rounding per REQ-024).
REQ-015 Outputs: X0 = A + P, then X1 = A - P, each sign-extended to bit_width+1; no saturation.
REQ-016 Latency: X0 valid 2 cycles after the cycle B is accepted; X1 valid the following cycle.
REQ-017 Back-to-back pairs on consecutive cycles yield a gap-free output stream at one sample per cycle; X1 is held in a dedicated register so it never collides with the next X0.
REQ-018 Idle cycles (en_radix low) between A and B are allowed: A is held indefinitely; phase does not change.
REQ-019 Idle cycles between pairs: no output beyond the pending X0/X1; valid_o low otherwise.
REQ-020 When valid_o is low, Re_o/Im_o hold their last value.
REQ-021 A SIZE-bit output counter increments on every valid_o; frame_done asserts when the counter equals N-1 with valid_o high; the counter then wraps to 0.
REQ-022 Pipeline stages: (1) capture A / capture B+W; (2) registered products; (3) X0 output, X1 to hold register; (4) X1 output.

Reset
REQ-023 rst high at a clock edge: phase=0, stored A discarded, pipeline valids cleared, counter=0, Re_o=Im_o=0, valid_o=0, frame_done=0; in-flight pairs produce no output; the first sample accepted after reset is A.

Configuration
REQ-024 RADIX2_ROUND_EN defined: 2048 added to each product sum before the 12-bit shift (round half up). Undefined: plain arithmetic shift (truncate toward minus infinity). Latency identical in both builds.

Structure
REQ-025 Shared package fft_pkg holds TW_WIDTH=14, TW_FRAC=12, TW_ONE=4096 and the rounding constant 2048.
REQ-026 Complex multiply with registered products is a sub-module cmplx_mult; pairing, add/subtract, hold register and counter stay in radix2_butterfly.

Verification
REQ-027 A=(100,0), B=(50,0), W=(4096,0), consecutive cycles -> X0=(150,0) 2 cycles after B, X1=(50,0) next cycle, valid_o high both cycles.
REQ-028 A=(100,0), B=(40,0), W=(0,-4096) -> X0=(100,-40), X1=(100,40).
REQ-029 A=(0,0), B=(3,0), W=(2048,0) -> X0=(2,0), X1=(-2,0) with RADIX2_ROUND_EN; X0=(1,0), X1=(-1,0) without.
REQ-030 A, 5 idle cycles, then B -> no valid_o during the gap; X0 exactly 2 cycles after B.
REQ-031 Accept A, assert rst one cycle, then pair A=(7,7), B=(1,1), W=(4096,0) -> pre-reset A never appears; X0=(8,8), X1=(6,6).
REQ-032 N=4, two pairs back-to-back -> 4 consecutive valid_o cycles; frame_done high only on the 4th; counter back at 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT constants and types.
// Twiddle factors are signed Q2.12: TW_ONE represents +1.0, TW_RND is the
// half-LSB added before the fractional shift when rounding is enabled.
package fft_pkg;

    localparam int unsigned TW_WIDTH = 14;
    localparam int unsigned TW_FRAC  = 12;
    localparam int          TW_ONE   = 4096;
    localparam int          TW_RND   = 2048;

    // Which half of a butterfly pair the next accepted sample belongs to.
    typedef enum logic {
        StWaitA,
        StWaitB
    } pair_state_e;

endpackage

// File: rtl/radix2_butterfly_if.sv
// Sample/result bundle for the radix-2 butterfly.
//   en_radix            : input-sample valid
//   Re_i, Im_i          : signed input sample (bit_width)
//   cos_data, sin_data  : signed Q2.12 twiddle (TW_WIDTH)
//   Re_o, Im_o          : signed butterfly result (bit_width+1)
//   valid_o             : result valid
//   frame_done          : pulse on the last result of a frame
// Modports: master drives samples and observes results; slave is the butterfly.
interface radix2_butterfly_if
    import fft_pkg::*;
#(
    parameter int unsigned bit_width = 29
) ();

    logic                        en_radix;
    logic signed [bit_width-1:0] Re_i;
    logic signed [bit_width-1:0] Im_i;
    logic signed [TW_WIDTH-1:0]  cos_data;
    logic signed [TW_WIDTH-1:0]  sin_data;
    logic signed [bit_width:0]   Re_o;
    logic signed [bit_width:0]   Im_o;
    logic                        valid_o;
    logic                        frame_done;

    modport master (
        output en_radix, Re_i, Im_i, cos_data, sin_data,
        input  Re_o, Im_o, valid_o, frame_done
    );

    modport slave (
        input  en_radix, Re_i, Im_i, cos_data, sin_data,
        output Re_o, Im_o, valid_o, frame_done
    );

endinterface

// File: rtl/radix2_butterfly_cmplx_mult.sv
// Complex multiply P = B * W with a registered result.
// Full-precision sums of the four partial products are shifted right by
// TW_FRAC. Build option: define RADIX2_ROUND_EN to add TW_RND before the
// shift (round half up); otherwise the shift truncates toward minus infinity.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_valid          : b_re/b_im/c/s hold a product to compute
//   b_re, b_im        : signed operand B (bit_width)
//   c, s              : signed Q2.12 twiddle
//   out_valid         : p_re/p_im updated this cycle (one cycle after in_valid)
//   p_re, p_im        : signed scaled product (bit_width+4)
module cmplx_mult
    import fft_pkg::*;
#(
    parameter int unsigned bit_width = 29
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic signed [bit_width-1:0] b_re,
    input  logic signed [bit_width-1:0] b_im,
    input  logic signed [TW_WIDTH-1:0]  c,
    input  logic signed [TW_WIDTH-1:0]  s,
    output logic                        out_valid,
    output logic signed [bit_width+3:0] p_re,
    output logic signed [bit_width+3:0] p_im
);

    localparam int unsigned MW = bit_width + TW_WIDTH;  // exact partial product
    localparam int unsigned SW = MW + 2;                // sum plus rounding headroom
    localparam int unsigned PW = bit_width + 4;

`ifdef RADIX2_ROUND_EN
    localparam int RND = TW_RND;
`else
    localparam int RND = 0;
`endif

    logic signed [MW-1:0] br_x, bi_x, c_x, s_x;
    logic signed [MW-1:0] rc, is_p, rs, ic;
    logic signed [SW-1:0] sum_re, sum_im;

    // Widen operands first so each multiply is evaluated at full precision.
    assign br_x = MW'(b_re);
    assign bi_x = MW'(b_im);
    assign c_x  = MW'(c);
    assign s_x  = MW'(s);

    always_comb begin
        rc     = br_x * c_x;
        is_p   = bi_x * s_x;
        rs     = br_x * s_x;
        ic     = bi_x * c_x;
        sum_re = SW'(rc) - SW'(is_p) + SW'(RND);
        sum_im = SW'(rs) + SW'(ic) + SW'(RND);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            p_re      <= '0;
            p_im      <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                p_re <= PW'(sum_re >>> TW_FRAC);
                p_im <= PW'(sum_im >>> TW_FRAC);
            end
        end
    end

endmodule

// File: rtl/radix2_butterfly.sv
// Streaming radix-2 DIT butterfly.
// Accepted samples pair up as A (even) then B (odd); the twiddle is taken with
// B. Each pair yields X0 = A + B*W, then X1 = A - B*W on the next cycle, with
// X0 appearing two cycles after B is accepted. A counter over emitted results
// pulses frame_done on the N-th result of each frame.
// Build option: RADIX2_ROUND_EN selects rounded product scaling (see cmplx_mult).
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : radix2_butterfly_if.slave (samples, twiddle, results, valid, frame_done)
module radix2_butterfly
    import fft_pkg::*;
#(
    parameter int unsigned bit_width = 29,
    parameter int unsigned N         = 16,
    parameter int unsigned SIZE      = 4
) (
    input logic             clk,
    input logic             rst,
    radix2_butterfly_if.slave bus
);

    localparam int unsigned PW = bit_width + 4;  // scaled product width
    localparam int unsigned XW = PW + 1;         // exact add/subtract width
    localparam int unsigned OW = bit_width + 1;  // output width (wraps, no saturation)

    // Pairing FSM.
    pair_state_e state_q, state_d;
    logic        take_a, take_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StWaitA;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.en_radix) begin
            unique case (state_q)
                StWaitA: state_d = StWaitB;
                StWaitB: state_d = StWaitA;
                default: state_d = StWaitA;
            endcase
        end
    end

    always_comb begin
        take_a = bus.en_radix && (state_q == StWaitA);
        take_b = bus.en_radix && (state_q == StWaitB);
    end

    // Stage 1: held A, captured B and twiddle, with A copied alongside B so the
    // held register is free for the next pair immediately.
    logic signed [bit_width-1:0] a_re_q, a_im_q;
    logic signed [bit_width-1:0] a1_re_q, a1_im_q;
    logic signed [bit_width-1:0] b_re_q, b_im_q;
    logic signed [TW_WIDTH-1:0]  c_q, s_q;
    logic                        s1_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_re_q     <= '0;
            a_im_q     <= '0;
            a1_re_q    <= '0;
            a1_im_q    <= '0;
            b_re_q     <= '0;
            b_im_q     <= '0;
            c_q        <= '0;
            s_q        <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= take_b;
            if (take_a) begin
                a_re_q <= bus.Re_i;
                a_im_q <= bus.Im_i;
            end
            if (take_b) begin
                b_re_q  <= bus.Re_i;
                b_im_q  <= bus.Im_i;
                c_q     <= bus.cos_data;
                s_q     <= bus.sin_data;
                a1_re_q <= a_re_q;
                a1_im_q <= a_im_q;
            end
        end
    end

    // Stage 2: registered products, with A delayed to stay aligned.
    logic                        p_valid;
    logic signed [PW-1:0]        p_re, p_im;
    logic signed [bit_width-1:0] a2_re_q, a2_im_q;

    cmplx_mult #(
        .bit_width (bit_width)
    ) u_cmplx_mult (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid_q),
        .b_re      (b_re_q),
        .b_im      (b_im_q),
        .c         (c_q),
        .s         (s_q),
        .out_valid (p_valid),
        .p_re      (p_re),
        .p_im      (p_im)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a2_re_q <= '0;
            a2_im_q <= '0;
        end else if (s1_valid_q) begin
            a2_re_q <= a1_re_q;
            a2_im_q <= a1_im_q;
        end
    end

    // Stages 3/4: X0 goes straight out, X1 waits one cycle in its own register.
    logic signed [OW-1:0] x0_re, x0_im, x1_re, x1_im;

    always_comb begin
        x0_re = OW'(XW'(a2_re_q) + XW'(p_re));
        x0_im = OW'(XW'(a2_im_q) + XW'(p_im));
        x1_re = OW'(XW'(a2_re_q) - XW'(p_re));
        x1_im = OW'(XW'(a2_im_q) - XW'(p_im));
    end

    logic signed [OW-1:0] re_q, im_q, re_d, im_d;
    logic signed [OW-1:0] x1_re_q, x1_im_q;
    logic                 x1_pend_q;
    logic                 valid_q, valid_d;
    logic                 frame_done_q, frame_done_d;
    logic [SIZE-1:0]      cnt_q, cnt_d;

    // Pairs are at least two cycles apart, so X0 and a pending X1 never coincide.
    always_comb begin
        re_d    = re_q;
        im_d    = im_q;
        valid_d = p_valid | x1_pend_q;
        if (p_valid) begin
            re_d = x0_re;
            im_d = x0_im;
        end else if (x1_pend_q) begin
            re_d = x1_re_q;
            im_d = x1_im_q;
        end
        frame_done_d = valid_d && (cnt_q == SIZE'(N - 1));
        cnt_d        = cnt_q;
        if (valid_d) begin
            cnt_d = (cnt_q == SIZE'(N - 1)) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            re_q         <= '0;
            im_q         <= '0;
            x1_re_q      <= '0;
            x1_im_q      <= '0;
            x1_pend_q    <= 1'b0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            re_q         <= re_d;
            im_q         <= im_d;
            valid_q      <= valid_d;
            frame_done_q <= frame_done_d;
            cnt_q        <= cnt_d;
            x1_pend_q    <= p_valid;
            if (p_valid) begin
                x1_re_q <= x1_re;
                x1_im_q <= x1_im;
            end
        end
    end

    assign bus.Re_o       = re_q;
    assign bus.Im_o       = im_q;
    assign bus.valid_o    = valid_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_radix2_butterfly.sv
// Bench for radix2_butterfly: a reference model predicts each result from the
// pairing/arithmetic rules and a compare process checks every cycle; directed
// cases pin literal values. A second instance with N=4 shares the stimulus to
// check frame boundaries.
module tb_radix2_butterfly;

    localparam int BW = 29;
    typedef logic signed [BW-1:0] in_t;
    typedef logic signed [13:0]   tw_t;
    typedef logic signed [BW:0]   out_t;
    typedef struct {
        out_t re;
        out_t im;
    } cplx_t;

`ifdef RADIX2_ROUND_EN
    localparam longint RND = 2048;
`else
    localparam longint RND = 0;
`endif

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_errors;

    radix2_butterfly_if #(.bit_width(BW)) bus16 ();
    radix2_butterfly_if #(.bit_width(BW)) bus4 ();

    assign bus4.en_radix = bus16.en_radix;
    assign bus4.Re_i     = bus16.Re_i;
    assign bus4.Im_i     = bus16.Im_i;
    assign bus4.cos_data = bus16.cos_data;
    assign bus4.sin_data = bus16.sin_data;

    radix2_butterfly #(.bit_width(BW), .N(16), .SIZE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    radix2_butterfly #(.bit_width(BW), .N(4), .SIZE(2)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state. Keys are the cyc value seen at the negedge where
    // the result must be visible.
    cplx_t exp_map[int];
    bit    rst_edges[int];
    bit    m_phase;
    in_t   m_ar, m_ai;

    task automatic model_step(input logic r, input logic en, input in_t re, input in_t im,
                              input tw_t c, input tw_t s);
        int     e;
        longint pr, pi;
        cplx_t  x0, x1;
        e = cyc;
        if (r) begin
            m_phase = 1'b0;
            for (int k = e + 1; k <= e + 5; k++) begin
                if (exp_map.exists(k)) exp_map.delete(k);
            end
            rst_edges[e] = 1'b1;
        end else if (en) begin
            if (!m_phase) begin
                m_ar    = re;
                m_ai    = im;
                m_phase = 1'b1;
            end else begin
                pr = (longint'(re) * longint'(c) - longint'(im) * longint'(s) + RND) >>> 12;
                pi = (longint'(re) * longint'(s) + longint'(im) * longint'(c) + RND) >>> 12;
                x0.re = out_t'(longint'(m_ar) + pr);
                x0.im = out_t'(longint'(m_ai) + pi);
                x1.re = out_t'(longint'(m_ar) - pr);
                x1.im = out_t'(longint'(m_ai) - pi);
                exp_map[e + 3] = x0;
                exp_map[e + 4] = x1;
                m_phase = 1'b0;
            end
        end
    endtask

    task automatic step(input logic r, input logic en, input longint re, input longint im,
                        input longint c, input longint s);
        @(negedge clk);
        rst              = r;
        bus16.en_radix   = en;
        bus16.Re_i       = in_t'(re);
        bus16.Im_i       = in_t'(im);
        bus16.cos_data   = tw_t'(c);
        bus16.sin_data   = tw_t'(s);
        model_step(r, en, in_t'(re), in_t'(im), tw_t'(c), tw_t'(s));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0, 0);
    endtask

    // A carries a random twiddle that must be ignored.
    task automatic pair(input longint ar, input longint ai, input longint br, input longint bi,
                        input longint c, input longint s);
        step(1'b0, 1'b1, ar, ai, longint'($urandom_range(0, 16383)) - 8192,
             longint'($urandom_range(0, 16383)) - 8192);
        step(1'b0, 1'b1, br, bi, c, s);
    endtask

    task automatic chk_out(input string name, input logic v, input longint re, input longint im);
        n_checks++;
        if (bus16.valid_o !== v ||
            (v && (bus16.Re_o !== out_t'(re) || bus16.Im_o !== out_t'(im)))) begin
            n_errors++;
            $display("FAIL %s: got valid=%0b re=%0d im=%0d, want valid=%0b re=%0d im=%0d",
                     name, bus16.valid_o, bus16.Re_o, bus16.Im_o, v, re, im);
        end
    endtask

    task automatic chk_bit(input string name, input logic got, input logic want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0b, want %0b", name, got, want);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    int   cnt16, cnt4;
    out_t last_re, last_im;

    task automatic compare_cycle();
        int    c;
        logic  ev, fd16, fd4;
        out_t  er, ei;
        c = cyc;
        if (rst_edges.exists(c - 1)) begin
            ev = 1'b0; fd16 = 1'b0; fd4 = 1'b0;
            last_re = '0; last_im = '0;
            cnt16 = 0; cnt4 = 0;
        end else if (exp_map.exists(c)) begin
            ev = 1'b1;
            last_re = exp_map[c].re;
            last_im = exp_map[c].im;
            fd16  = (cnt16 == 15);
            fd4   = (cnt4 == 3);
            cnt16 = (cnt16 + 1) % 16;
            cnt4  = (cnt4 + 1) % 4;
        end else begin
            ev = 1'b0; fd16 = 1'b0; fd4 = 1'b0;
        end
        er = last_re;
        ei = last_im;
        n_checks++;
        if (bus16.valid_o !== ev || bus16.Re_o !== er || bus16.Im_o !== ei ||
            bus16.frame_done !== fd16) begin
            n_errors++;
            $display("FAIL cycle%0d n16: got v=%0b re=%0d im=%0d fd=%0b, want v=%0b re=%0d im=%0d fd=%0b",
                     c, bus16.valid_o, bus16.Re_o, bus16.Im_o, bus16.frame_done,
                     ev, er, ei, fd16);
        end
        n_checks++;
        if (bus4.valid_o !== ev || bus4.Re_o !== er || bus4.Im_o !== ei ||
            bus4.frame_done !== fd4) begin
            n_errors++;
            $display("FAIL cycle%0d n4: got v=%0b re=%0d im=%0d fd=%0b, want v=%0b re=%0d im=%0d fd=%0b",
                     c, bus4.valid_o, bus4.Re_o, bus4.Im_o, bus4.frame_done,
                     ev, er, ei, fd4);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (cyc >= 3) compare_cycle();
        end
    end

    task automatic frame4_run(input string name);
        pair(1, 2, 3, 4, 4096, 0);
        pair(5, 6, 7, 8, 0, 4096);
        for (int k = 0; k < 4; k++) begin
            idle(1);
            chk_bit({name, "_valid"}, bus4.valid_o, 1'b1);
            chk_bit({name, "_fd4"}, bus4.frame_done, (k == 3));
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_phase  = 1'b0;
        m_ar     = '0;
        m_ai     = '0;
        cnt16    = 0;
        cnt4     = 0;
        last_re  = '0;
        last_im  = '0;
        rst            = 1'b1;
        bus16.en_radix = 1'b0;
        bus16.Re_i     = '0;
        bus16.Im_i     = '0;
        bus16.cos_data = '0;
        bus16.sin_data = '0;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 0, 0, 0);
        chk_out("reset_state", 1'b0, 0, 0);
        chk_bit("reset_re_zero", (bus16.Re_o == '0 && bus16.Im_o == '0), 1'b1);
        chk_bit("reset_fd", bus16.frame_done, 1'b0);
        idle(1);

        // Identity twiddle.
        pair(100, 0, 50, 0, 4096, 0);
        idle(3);
        chk_out("w1_x0", 1'b1, 150, 0);
        idle(1);
        chk_out("w1_x1", 1'b1, 50, 0);

        // W = -j.
        pair(100, 0, 40, 0, 0, -4096);
        idle(3);
        chk_out("wj_x0", 1'b1, 100, -40);
        idle(1);
        chk_out("wj_x1", 1'b1, 100, 40);

        // Half-LSB product: rounding vs truncation.
        pair(0, 0, 3, 0, 2048, 0);
        idle(3);
`ifdef RADIX2_ROUND_EN
        chk_out("rnd_x0", 1'b1, 2, 0);
        idle(1);
        chk_out("rnd_x1", 1'b1, -2, 0);
`else
        chk_out("trunc_x0", 1'b1, 1, 0);
        idle(1);
        chk_out("trunc_x1", 1'b1, -1, 0);
`endif
        idle(2);

        // A held across idle cycles.
        step(1'b0, 1'b1, 100, 0, 7, 7);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk_out("gap_idle", 1'b0, 0, 0);
        end
        step(1'b0, 1'b1, 50, 0, 4096, 0);
        idle(2);
        chk_out("gap_early", 1'b0, 0, 0);
        idle(1);
        chk_out("gap_x0", 1'b1, 150, 0);
        idle(2);

        // Reset discards a stored A.
        step(1'b0, 1'b1, 9, 9, 0, 0);
        step(1'b1, 1'b0, 0, 0, 0, 0);
        pair(7, 7, 1, 1, 4096, 0);
        idle(3);
        chk_out("rst_x0", 1'b1, 8, 8);
        idle(1);
        chk_out("rst_x1", 1'b1, 6, 6);

        // Frame boundaries on the N=4 instance.
        step(1'b1, 1'b0, 0, 0, 0, 0);
        frame4_run("frame_a");
        frame4_run("frame_b");
        idle(2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic   r, en;
            longint c, s;
            r  = ($urandom_range(0, 199) == 0);
            en = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 3))
                0:       begin c = 4096;  s = 0;     end
                1:       begin c = -8192; s = 8191;  end
                default: begin
                    c = longint'($urandom_range(0, 16383)) - 8192;
                    s = longint'($urandom_range(0, 16383)) - 8192;
                end
            endcase
            step(r, en, longint'(in_t'($urandom)), longint'(in_t'($urandom)), c, s);
        end
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
